// File: rtl/rv_muldiv_unit_if.sv
// rtl/rv_muldiv_unit_if.sv - start/busy/done handshake bundle for the RV32M multiply/divide unit
interface rv_muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, a, b, input busy, done, result);
  modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
// Define MULDIV_FAST_MUL_EN to route all multiplies through a single-cycle 32x32 multiplier.
module rv_muldiv_unit #(parameter int XLEN = 32) (
  input  logic             clk,
  input  logic             reset,
  rv_muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              spec_q, spec_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   a_abs, b_abs, spec_val, quo_fix, rem_fix;
  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    accept      = bus.start && !busy_q;
    is_div      = bus.funct3[2];
    a_sgn       = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_sgn       = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    a_neg       = a_sgn && bus.a[XLEN-1];
    b_neg       = b_sgn && bus.b[XLEN-1];
    a_abs       = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_abs       = b_neg ? (~bus.b + 1'b1) : bus.b;
    div_by_zero = is_div && (bus.b == '0);
    div_ovf     = is_div && !bus.funct3[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    special     = div_by_zero || div_ovf;
    if (div_by_zero) spec_val = bus.funct3[1] ? bus.a : '1;
    else             spec_val = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};

    // acc holds {partial product hi, shifted-out lo} for multiply, {remainder, quotient} for divide
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q};
    rem_shift = {acc_q[2*XLEN-1:XLEN], a_mag_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, b_mag_q};
    prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

    state_d   = state_q;
    op_d      = op_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    spec_d    = spec_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    case (state_q)
      CALC: begin
        if (op_q[2]) begin
          if (!rem_diff[XLEN]) acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          a_mag_d = a_mag_q << 1;
        end else begin
          acc_d   = {(b_mag_q[0] ? mul_sum : {1'b0, acc_q[2*XLEN-1:XLEN]}), acc_q[XLEN-1:1]};
          b_mag_d = b_mag_q >> 1;
        end
        if (cnt_q == 5'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      FIX: begin
        if (spec_q)        result_d = acc_q[XLEN-1:0];
        else if (op_q[2])  result_d = op_q[1] ? rem_fix : quo_fix;
        else               result_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                           : prod_fix[2*XLEN-1:XLEN];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d      = bus.funct3;
      a_mag_d   = a_abs;
      b_mag_d   = b_abs;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      spec_d    = special;
      acc_d     = '0;
      cnt_d     = 5'd31;
      if (special) begin
        acc_d   = {{XLEN{1'b0}}, spec_val};
        state_d = FIX;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!is_div) begin
        acc_d   = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
        state_d = FIX;
      end
`endif
      else begin
        state_d = CALC;
      end
    end

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      spec_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      spec_q    <= spec_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb/tb_rv_muldiv_unit.sv - directed scoreboard bench for rv_muldiv_unit
module tb_rv_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 2;

  typedef struct {
    string       tag;
    logic [31:0] result;
    int          edges;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  sb_t  sb[$];

  rv_muldiv_unit_if #(.XLEN(32)) bus ();
  rv_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives a request, returns #1 after the acceptance edge with operands scrambled.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag, input bit push);
    if (push) sb.push_back('{tag, exp, lat});
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom_range(0, 7));
    bus.a      = $urandom;
    bus.b      = $urandom;
  endtask

  task automatic wait_done(input int n0);
    int  n = n0;
    sb_t e;
    while (bus.done !== 1'b1 && n < 80) begin
      @(posedge clk);
      n++;
      #1;
    end
    e = sb.pop_front();
    check({e.tag, "_res"}, bus.result, e.result);
    check({e.tag, "_lat"}, 32'(n), 32'(e.edges));
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    start_op(f3, a, b, exp, lat, tag, 1'b1);
    wait_done(1);
    @(negedge clk);
  endtask

  initial begin
    bit saw_done;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul", 1'b1);
    wait_done(1);
    @(posedge clk);
    #1;
    check("done_pulse", {31'b0, bus.done}, 32'd0);
    check("result_hold", bus.result, 32'hFFFF_FFEB);
    @(negedge clk);

    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh");
    run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulhu");
    run_op(3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MUL_LAT, "mulhsu");
    run_op(3'b000, 32'h0001_2345, 32'h0000_1000, 32'h1234_5000, MUL_LAT, "mul_pos");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem");
    run_op(3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, DIV_LAT, "divu_max");
    run_op(3'b100, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, SPC_LAT, "div0");
    run_op(3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234, SPC_LAT, "remu0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT, "rem_ovf");

    // Stray start while busy must not disturb the running divide.
    start_op(3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, "ign", 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.a      = 32'd3;
    bus.b      = 32'd5;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    wait_done(6);

    // Back-to-back: next request presented during the DONE cycle.
    @(negedge clk);
    start_op(3'b111, 32'd100, 32'd9, 32'd1, DIV_LAT, "b2b_a", 1'b1);
    wait_done(1);
    start_op(3'b100, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, DIV_LAT, "b2b_b", 1'b1);
    wait_done(1);

    // Reset in the middle of a divide aborts it silently.
    @(negedge clk);
    start_op(3'b100, 32'd1000, 32'd3, 32'd0, DIV_LAT, "abort", 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    @(negedge clk);
    run_op(3'b100, 32'd1000, 32'd3, 32'd333, DIV_LAT, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit alongside the single-cycle ALU; takes the same 32-bit rs1/rs2 operands.
- Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with a start/busy/done handshake.
- Datapath stalls the PC while busy; the result is written back on done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted on a rising edge when busy=0
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand (dividend / multiplicand)
- b  input  32  rs2 operand (divisor / multiplier)
- busy  output  1  operation in progress; new start ignored
- done  output  1  one-cycle pulse; result valid
- result  output  32  registered result, held until the next accepted start

Behaviour:
- Reset: synchronous, active-high, applies on the clk edge.
  - State goes to IDLE; busy=0, done=0, result=0; counter and internal registers cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE.
  - busy=1 in CALC and FIX.
  - done=1 only in DONE.
  - A start is accepted in IDLE or DONE, so back-to-back operations are allowed.
- Acceptance edge E0 (start=1, busy=0):
  - Latch funct3.
  - Latch operand magnitudes and sign flags: signed ops take |a| and |b|; MULHSU treats only a as signed.
  - Clear the 64-bit accumulator and set counter=31.
- Normal path:
  - IDLE/DONE -> CALC at E0.
  - CALC does one iteration per edge for 32 edges (E0+1..E0+32), then -> FIX.
  - FIX applies sign correction, registers result and -> DONE at E0+33.
  - DONE -> IDLE on the next edge unless start=1.
  - done is high in the cycle after E0+33, i.e. 34 edges after acceptance.
- Multiply: shift-add, one multiplier bit per iteration, 64-bit product.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
  - The product is negated when the operand signs differ (signed ops only).
- Divide: restoring, one quotient bit per iteration, 33-bit partial remainder.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases (no CALC): IDLE/DONE -> FIX at E0, FIX -> DONE at E0+1; done is high in the cycle after E0+1.
  - b=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- Handshake rules:
  - start while busy=1 is ignored and does not affect the running operation.
  - Operand and funct3 changes after E0 have no effect.
- All outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- When defined, all multiply ops use a single-cycle 32x32->64 multiplier: IDLE/DONE -> FIX at E0, done is high after E0+1, and CALC is used only for divides.
- When undefined, multiplies use the 32-iteration shift-add path with the 34-edge latency.
- Divide behaviour and all special cases are identical in both builds.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3): result=0xFFFFFFEB, done exactly 34 edges after acceptance (2 with MULDIV_FAST_MUL_EN).
- MULH, MULHU, MULHSU with a=b=0x80000000: results 0x40000000, 0x40000000, 0xC0000000 respectively.
- DIV a=-7 (0xFFFFFFF9), b=2: quotient 0xFFFFFFFD. REM same operands: 0xFFFFFFFF. DIVU 100/7=14, REMU 100%7=2.
- Divide by zero, a=0x1234: DIV=0xFFFFFFFF, REMU=0x1234, done 2 edges after acceptance. Overflow case: DIV=0x80000000, REM=0.
- start pulsed at edge 5 of a divide with different operands: ignored, original result unchanged. start held high in the DONE cycle: next operation accepted back-to-back.
- reset asserted at iteration 10 of DIV: next edge gives busy=0, done=0, result=0, and no done pulse follows. A fresh start afterwards completes correctly.
